// File: rtl/kf8255_pkg.sv
// Shared encodings for the 8255 Port A group: mode field values, Port C bit
// positions of the group-A handshake lines, and the handshake FSM states.
package kf8255_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;

  localparam logic [2:0] PC_INTR_A = 3'd3;
  localparam logic [2:0] PC_STB_A  = 3'd4;
  localparam logic [2:0] PC_IBF_A  = 3'd5;
  localparam logic [2:0] PC_ACK_A  = 3'd6;
  localparam logic [2:0] PC_OBF_A  = 3'd7;

  typedef enum logic [1:0] {
    IN_EMPTY  = 2'd0,
    IN_STROBE = 2'd1,
    IN_FULL   = 2'd2
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE  = 2'd0,
    OUT_FULL  = 2'd1,
    OUT_ACKED = 2'd2
  } out_state_e;

endpackage

// File: rtl/kf8255_edge_sync.sv
// Synchroniser chain for an asynchronous active-low pin, followed by a
// previous-value flop that yields single-cycle rise/fall pulses.
module kf8255_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Idle level of the strobe/ack pins is high, so reset to 1 to avoid a
  // spurious fall pulse after reset.
  always_ff @(negedge clock) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/kf8255_port_a_group.sv
// 8255 group-A Port A: mode 0 basic I/O and mode 1 strobed I/O handshakes.
// Mode 2 bidirectional operation is built when KF8255_PORT_A_MODE2_EN is defined.
module kf8255_port_a_group
  import kf8255_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] internal_data_bus,
  input  logic       write_port_a,
  input  logic       read_port_a,
  input  logic       write_control,
  input  logic [7:0] port_a_in,
  output logic [7:0] port_a_out,
  output logic       port_a_io,
  input  logic       stb_n,
  input  logic       ack_n,
  output logic       ibf,
  output logic       obf_n,
  output logic       intr,
  output logic [7:0] read_data,
  output logic [1:0] group_a_mode
);

  function automatic logic [1:0] decode_mode(input logic [1:0] field);
`ifdef KF8255_PORT_A_MODE2_EN
    return field[1] ? MODE2 : field;
`else
    return field[1] ? MODE1 : field;
`endif
  endfunction

  logic       stb_level, stb_rise, stb_fall;
  logic       ack_level, ack_rise, ack_fall;
  logic       unused_levels;

  logic [1:0] mode_q, mode_d;
  logic       dir_in_q, dir_in_d;
  logic [7:0] port_a_out_q, port_a_out_d;
  logic [7:0] in_latch_q, in_latch_d;
  logic       ibf_q, ibf_d;
  logic       obf_n_q, obf_n_d;
  logic       in_intr_q, in_intr_d;
  logic       out_intr_q, out_intr_d;
  logic       inte_in_q, inte_in_d;
  logic       inte_out_q, inte_out_d;
  logic       read_prev_q, read_prev_d;
  in_state_e  in_state_q, in_state_d;
  out_state_e out_state_q, out_state_d;

  logic       is_m2, run_in, run_out;
  logic       ctl_mode_set, ctl_bsr;
  logic [2:0] bsr_bit;
  logic       bsr_val;
  logic       read_rise, read_fall;

  kf8255_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (stb_n),
    .level   (stb_level),
    .rise    (stb_rise),
    .fall    (stb_fall)
  );

  kf8255_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (ack_n),
    .level   (ack_level),
    .rise    (ack_rise),
    .fall    (ack_fall)
  );

  assign unused_levels = stb_level ^ ack_level;

`ifdef KF8255_PORT_A_MODE2_EN
  assign is_m2 = (mode_q == MODE2);
`else
  assign is_m2 = 1'b0;
`endif

  assign run_in       = ((mode_q == MODE1) && dir_in_q) || is_m2;
  assign run_out      = ((mode_q == MODE1) && !dir_in_q) || is_m2;
  assign ctl_mode_set = write_control & internal_data_bus[7];
  assign ctl_bsr      = write_control & ~internal_data_bus[7];
  assign bsr_bit      = internal_data_bus[3:1];
  assign bsr_val      = internal_data_bus[0];
  assign read_rise    = read_port_a & ~read_prev_q;
  assign read_fall    = ~read_port_a & read_prev_q;

  always_comb begin
    mode_d       = mode_q;
    dir_in_d     = dir_in_q;
    port_a_out_d = port_a_out_q;
    in_latch_d   = in_latch_q;
    ibf_d        = ibf_q;
    obf_n_d      = obf_n_q;
    in_intr_d    = in_intr_q;
    out_intr_d   = out_intr_q;
    inte_in_d    = inte_in_q;
    inte_out_d   = inte_out_q;
    in_state_d   = in_state_q;
    out_state_d  = out_state_q;
    read_prev_d  = read_port_a;

    if (ctl_mode_set) begin
      mode_d       = decode_mode(internal_data_bus[6:5]);
      dir_in_d     = internal_data_bus[4];
      port_a_out_d = 8'h00;
      in_latch_d   = 8'h00;
      ibf_d        = 1'b0;
      obf_n_d      = 1'b1;
      in_intr_d    = 1'b0;
      out_intr_d   = 1'b0;
      inte_in_d    = 1'b0;
      inte_out_d   = 1'b0;
      in_state_d   = IN_EMPTY;
      out_state_d  = OUT_IDLE;
    end else begin
      // INTE is updated first so a same-edge completion sees the new enable.
      if (ctl_bsr && run_in && (bsr_bit == PC_STB_A)) begin
        inte_in_d = bsr_val;
        if (!bsr_val) in_intr_d = 1'b0;
      end
      if (ctl_bsr && run_out && (bsr_bit == PC_ACK_A)) begin
        inte_out_d = bsr_val;
        if (!bsr_val) out_intr_d = 1'b0;
      end

      if ((mode_q == MODE0) && write_port_a) begin
        port_a_out_d = internal_data_bus;
      end

      if (run_out) begin
        if (write_port_a) begin
          port_a_out_d = internal_data_bus;
          obf_n_d      = 1'b0;
          out_intr_d   = 1'b0;
          out_state_d  = OUT_FULL;
        end else begin
          case (out_state_q)
            OUT_FULL: if (ack_fall) begin
              obf_n_d     = 1'b1;
              out_state_d = OUT_ACKED;
            end
            OUT_ACKED: if (ack_rise) begin
              out_intr_d  = inte_out_d;
              out_state_d = OUT_IDLE;
            end
            default: ;
          endcase
        end
      end

      if (run_in) begin
        case (in_state_q)
          IN_EMPTY: if (stb_fall) begin
            in_latch_d = port_a_in;
            ibf_d      = 1'b1;
            in_state_d = IN_STROBE;
          end
          IN_STROBE: if (stb_rise) begin
            in_intr_d  = inte_in_d;
            in_state_d = IN_FULL;
          end
          IN_FULL: begin
            // A new strobe beats a read that ends on the same edge.
            if (stb_fall) begin
              in_latch_d = port_a_in;
              ibf_d      = 1'b1;
              in_state_d = IN_STROBE;
            end else if (read_fall) begin
              ibf_d      = 1'b0;
              in_state_d = IN_EMPTY;
            end
          end
          default: ;
        endcase
        if (read_rise) in_intr_d = 1'b0;
      end
    end
  end

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      mode_q       <= MODE0;
      dir_in_q     <= 1'b1;
      port_a_out_q <= 8'h00;
      in_latch_q   <= 8'h00;
      ibf_q        <= 1'b0;
      obf_n_q      <= 1'b1;
      in_intr_q    <= 1'b0;
      out_intr_q   <= 1'b0;
      inte_in_q    <= 1'b0;
      inte_out_q   <= 1'b0;
      read_prev_q  <= 1'b0;
      in_state_q   <= IN_EMPTY;
      out_state_q  <= OUT_IDLE;
    end else begin
      mode_q       <= mode_d;
      dir_in_q     <= dir_in_d;
      port_a_out_q <= port_a_out_d;
      in_latch_q   <= in_latch_d;
      ibf_q        <= ibf_d;
      obf_n_q      <= obf_n_d;
      in_intr_q    <= in_intr_d;
      out_intr_q   <= out_intr_d;
      inte_in_q    <= inte_in_d;
      inte_out_q   <= inte_out_d;
      read_prev_q  <= read_prev_d;
      in_state_q   <= in_state_d;
      out_state_q  <= out_state_d;
    end
  end

  always_comb begin
    read_data = port_a_out_q;
    if (mode_q == MODE0) begin
      read_data = dir_in_q ? port_a_in : port_a_out_q;
    end else if (run_in) begin
      read_data = in_latch_q;
    end
  end

  always_comb begin
    port_a_io = ~dir_in_q;
`ifdef KF8255_PORT_A_MODE2_EN
    if (is_m2) port_a_io = ~ack_level;
`endif
  end

  assign port_a_out   = port_a_out_q;
  assign ibf          = ibf_q;
  assign obf_n        = obf_n_q;
  assign intr         = in_intr_q | out_intr_q;
  assign group_a_mode = mode_q;

endmodule

// File: tb/tb_kf8255_port_a_group.sv
// Directed bench for kf8255_port_a_group; mode 2 checks compile in when
// KF8255_PORT_A_MODE2_EN is defined.
module tb_kf8255_port_a_group;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] internal_data_bus = 8'h00;
  logic       write_port_a = 1'b0;
  logic       read_port_a = 1'b0;
  logic       write_control = 1'b0;
  logic [7:0] port_a_in = 8'hA5;
  logic [7:0] port_a_out;
  logic       port_a_io;
  logic       stb_n = 1'b1;
  logic       ack_n = 1'b1;
  logic       ibf;
  logic       obf_n;
  logic       intr;
  logic [7:0] read_data;
  logic [1:0] group_a_mode;

  int total = 0;
  int bad = 0;

  kf8255_port_a_group #(.SYNC_STAGES(2)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .internal_data_bus (internal_data_bus),
    .write_port_a      (write_port_a),
    .read_port_a       (read_port_a),
    .write_control     (write_control),
    .port_a_in         (port_a_in),
    .port_a_out        (port_a_out),
    .port_a_io         (port_a_io),
    .stb_n             (stb_n),
    .ack_n             (ack_n),
    .ibf               (ibf),
    .obf_n             (obf_n),
    .intr              (intr),
    .read_data         (read_data),
    .group_a_mode      (group_a_mode)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the active (falling) edge and outputs
  // are sampled at that same point.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wr_ctl(input logic [7:0] v);
    internal_data_bus = v;
    write_control = 1'b1;
    cyc(1);
    write_control = 1'b0;
  endtask

  task automatic wr_a(input logic [7:0] v);
    internal_data_bus = v;
    write_port_a = 1'b1;
    cyc(1);
    write_port_a = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] v);
    port_a_in = v;
    stb_n = 1'b0;
    cyc(3);
    stb_n = 1'b1;
    cyc(3);
  endtask

  initial begin
    cyc(2);
    reset_n = 1'b1;
    chk("rst_out", port_a_out, 8'h00);
    chk("rst_io", port_a_io, 8'd0);
    chk("rst_ibf", ibf, 8'd0);
    chk("rst_obf_n", obf_n, 8'd1);
    chk("rst_intr", intr, 8'd0);
    chk("rst_mode", group_a_mode, 8'd0);
    chk("rst_read_pins", read_data, 8'hA5);

    // Mode 0 output
    wr_ctl(8'h80);
    chk("m0o_io", port_a_io, 8'd1);
    wr_a(8'h5A);
    chk("m0o_out", port_a_out, 8'h5A);
    read_port_a = 1'b1;
    #1;
    chk("m0o_read", read_data, 8'h5A);
    read_port_a = 1'b0;
    cyc(1);

    // Mode 0 input: read path is combinational from the pins
    wr_ctl(8'h90);
    port_a_in = 8'h42;
    #1;
    chk("m0i_io", port_a_io, 8'd0);
    chk("m0i_out_cleared", port_a_out, 8'h00);
    chk("m0i_read", read_data, 8'h42);
    port_a_in = 8'h24;
    #1;
    chk("m0i_read_comb", read_data, 8'h24);

    // Mode 1 input
    wr_ctl(8'hB0);
    chk("m1i_mode", group_a_mode, 8'd1);
    wr_ctl(8'h09);
    port_a_in = 8'h3C;
    stb_n = 1'b0;
    cyc(2);
    chk("m1i_ibf_early", ibf, 8'd0);
    cyc(1);
    chk("m1i_ibf_set", ibf, 8'd1);
    stb_n = 1'b1;
    port_a_in = 8'h00;
    cyc(2);
    chk("m1i_intr_early", intr, 8'd0);
    cyc(1);
    chk("m1i_intr_set", intr, 8'd1);
    chk("m1i_read", read_data, 8'h3C);
    read_port_a = 1'b1;
    cyc(1);
    chk("m1i_intr_rd", intr, 8'd0);
    chk("m1i_ibf_rd", ibf, 8'd1);
    read_port_a = 1'b0;
    cyc(1);
    chk("m1i_ibf_clr", ibf, 8'd0);

    // Overrun: second strobe while full
    strobe(8'h11);
    chk("ovr_ibf_a", ibf, 8'd1);
    strobe(8'h77);
    chk("ovr_latch", read_data, 8'h77);
    chk("ovr_ibf", ibf, 8'd1);

    // Collision: strobe fall seen on the same edge the read ends
    read_port_a = 1'b1;
    cyc(1);
    port_a_in = 8'h99;
    stb_n = 1'b0;
    cyc(2);
    read_port_a = 1'b0;
    cyc(1);
    chk("col_ibf", ibf, 8'd1);
    cyc(1);
    chk("col_ibf_hold", ibf, 8'd1);
    stb_n = 1'b1;
    cyc(3);
    chk("col_intr", intr, 8'd1);
    chk("col_latch", read_data, 8'h99);
    wr_ctl(8'h08);
    chk("inte_clr_intr", intr, 8'd0);

    // Mode 1 output
    wr_ctl(8'hA0);
    chk("m1o_io", port_a_io, 8'd1);
    chk("m1o_ibf_cleared", ibf, 8'd0);
    wr_ctl(8'h0D);
    wr_a(8'hC3);
    chk("m1o_obf", obf_n, 8'd0);
    chk("m1o_out", port_a_out, 8'hC3);
    ack_n = 1'b0;
    cyc(2);
    chk("m1o_obf_early", obf_n, 8'd0);
    cyc(1);
    chk("m1o_obf_ack", obf_n, 8'd1);
    ack_n = 1'b1;
    cyc(2);
    chk("m1o_intr_early", intr, 8'd0);
    cyc(1);
    chk("m1o_intr", intr, 8'd1);
    wr_a(8'h11);
    chk("m1o_intr_wr", intr, 8'd0);
    chk("m1o_obf2", obf_n, 8'd0);
    chk("m1o_out2", port_a_out, 8'h11);

    // Reset in the middle of an output handshake
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk("rmid_out", port_a_out, 8'h00);
    chk("rmid_obf_n", obf_n, 8'd1);
    chk("rmid_intr", intr, 8'd0);
    chk("rmid_mode", group_a_mode, 8'd0);

`ifdef KF8255_PORT_A_MODE2_EN
    wr_ctl(8'hC0);
    chk("m2_mode", group_a_mode, 8'd2);
    chk("m2_io_idle", port_a_io, 8'd0);
    wr_ctl(8'h09);
    wr_ctl(8'h0D);
    wr_a(8'h5A);
    chk("m2_obf", obf_n, 8'd0);
    ack_n = 1'b0;
    cyc(2);
    chk("m2_io_ack", port_a_io, 8'd1);
    cyc(1);
    chk("m2_obf_ack", obf_n, 8'd1);
    ack_n = 1'b1;
    cyc(3);
    chk("m2_io_rel", port_a_io, 8'd0);
    chk("m2_intr_out", intr, 8'd1);
    wr_a(8'h01);
    chk("m2_intr_wr", intr, 8'd0);
    strobe(8'h66);
    chk("m2_ibf", ibf, 8'd1);
    chk("m2_intr_in", intr, 8'd1);
    chk("m2_read", read_data, 8'h66);
    read_port_a = 1'b1;
    cyc(1);
    chk("m2_intr_rd", intr, 8'd0);
    read_port_a = 1'b0;
    cyc(1);
    chk("m2_ibf_clr", ibf, 8'd0);
`else
    wr_ctl(8'hC0);
    chk("m2off_mode", group_a_mode, 8'd1);
    chk("m2off_io", port_a_io, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kf8255_port_a_group.md
Name: kf8255_port_a_group

Overview:
- Port A data and handshake stage; sits directly downstream of the 8255 bus control logic.
- Consumes the registered internal data bus and the write_port_a / read_port_a / write_control strobes.
- Implements 8255 group-A Port A behaviour: mode 0 (basic I/O) and mode 1 (strobed I/O with IBF/OBF/INTR).
- Supplies Port A read data back to the bus side and the PC3..PC7 handshake bits to the Port C block.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on the stb_n and ack_n pins (minimum 1).

Ports:
- clock  input  1  system clock; all flops update on its negative edge.
- reset_n  input  1  synchronous, active-low reset (sampled on the same negative clock edge).
- internal_data_bus  input  8  latched CPU write data.
- write_port_a  input  1  one-cycle write strobe to Port A.
- read_port_a  input  1  level; high while the CPU reads Port A.
- write_control  input  1  one-cycle control-word write strobe.
- port_a_in  input  8  Port A pin input.
- port_a_out  output  8  Port A output latch.
- port_a_io  output  1  1 = drive port_a_out onto the pins; 0 = pins are input.
- stb_n  input  1  mode 1 input strobe (PC4).
- ack_n  input  1  mode 1 output acknowledge (PC6).
- ibf  output  1  input buffer full (PC5).
- obf_n  output  1  output buffer full, active-low (PC7).
- intr  output  1  interrupt request (PC3).
- read_data  output  8  data returned for a Port A read.
- group_a_mode  output  2  current mode: 00 = mode 0, 01 = mode 1, 10 = mode 2.

Behaviour:
- Reset (reset_n = 0 at a clock edge), all outputs:
  - mode 0, input direction; port_a_io = 0, port_a_out = 00, input latch = 00.
  - ibf = 0, obf_n = 1, intr = 0, INTE = 0, FSM in IDLE.
- Mode-set control word (write_control and bit7 = 1):
  - group_a_mode <= bits6:5, with 11 stored as 10.
  - Direction <= bit4 (1 = input).
  - Clears port_a_out, input latch, ibf, INTE and intr; sets obf_n = 1; FSM to IDLE.
  - Takes effect at the next edge; overrides any handshake in progress.
- Bit set/reset control word (bit7 = 0): bits3:1 select the Port C bit, bit0 is the value.
  - Mode 1 input: bit 4 drives INTE.
  - Mode 1 output: bit 6 drives INTE.
  - All other bits are ignored by this block.
- Mode 0:
  - write_port_a latches internal_data_bus into port_a_out (1-cycle latency).
  - Input direction: read_data = port_a_in, unlatched, combinational.
  - Output direction: read_data = port_a_out.
  - ibf = 0, obf_n = 1, intr = 0.
- Edge detection: stb_n and ack_n pass through SYNC_STAGES flops (reset to 1), then a previous-value flop. An edge is seen the cycle after the synchronised value changes.
- Mode 1 input FSM, states EMPTY, STROBE, FULL:
  - EMPTY/FULL -> STROBE on a stb_n fall: latch port_a_in, ibf <= 1.
  - STROBE -> FULL on a stb_n rise: intr <= INTE.
  - read_port_a first seen high: intr <= 0.
  - read_port_a 1->0 in FULL: ibf <= 0, FSM -> EMPTY.
  - A strobe while FULL overwrites the latch; ibf stays 1.
  - stb_n fall and read end on the same edge: the strobe wins (ibf stays 1, FSM -> STROBE).
  - read_data = input latch.
- Mode 1 output FSM, states IDLE, FULL, ACKED:
  - write_port_a: latch data, obf_n <= 0, intr <= 0, FSM -> FULL (from any state).
  - ack_n fall in FULL: obf_n <= 1, FSM -> ACKED.
  - ack_n rise in ACKED: intr <= INTE, FSM -> IDLE.
  - ack_n edges seen in IDLE are ignored.
  - port_a_io = 1 at all times in mode 1 output (output latch driven continuously).
- INTE cleared while intr = 1: intr drops on the next edge.

Optional Feature:
- Macro: KF8255_PORT_A_MODE2_EN.
- Defined: mode 2 (bidirectional) is supported.
  - Both the input FSM and the output FSM run concurrently.
  - INTE1 (output) comes from PC6 and INTE2 (input) from PC4.
  - intr = (output-complete & INTE1) | (ibf-complete & INTE2).
  - port_a_io = ~ack_n after synchronisation.
  - Direction bit is ignored.
- Not defined: a mode field of 1x is decoded as mode 1; group_a_mode reports 01.

Decomposition:
- Shared package kf8255_pkg:
  - Mode encodings MODE0/MODE1/MODE2.
  - Port C bit indices PC_INTR_A=3, PC_STB_A=4, PC_IBF_A=5, PC_ACK_A=6, PC_OBF_A=7.
  - FSM state enums for the input and output FSMs.
- One natural sub-module: kf8255_edge_sync, the parameterised synchroniser plus rise/fall pulse generator, instantiated for stb_n and ack_n.

Test Plan:
- Reset mid-handshake: mode 1 output with obf_n = 0, assert reset_n = 0 for 1 edge -> port_a_out = 00, obf_n = 1, intr = 0, group_a_mode = 00.
- Mode 0 output: write control 0x80, then write_port_a with 0x5A -> port_a_out = 5A one edge later, port_a_io = 1; a read returns 5A.
- Mode 1 input:
  - Setup: write control 0xB0, then BSR 0x09 (INTE = 1); port_a_in = 0x3C; pulse stb_n low 3 cycles.
  - Expected: ibf = 1 at 1 + SYNC_STAGES edges after the fall; intr = 1 after the rise; read_data = 3C.
  - Read pulse: intr = 0 while reading, ibf = 0 after read_port_a falls.
- Mode 1 output:
  - Setup: write control 0xA0, then BSR 0x0D; write 0xC3.
  - Expected: obf_n = 0; ack_n low -> obf_n = 1; ack_n high -> intr = 1; next write 0x11 -> intr = 0.
- Overrun and collision:
  - Second stb_n pulse while ibf = 1 with port_a_in = 0x77 -> latch = 77, ibf stays 1.
  - stb_n fall on the same edge as the read end -> ibf remains 1.
- Mode 2, macro defined: write control 0xC0, INTE1 = INTE2 = 1; interleave a write with ack and a strobe with read -> intr asserts for each completion and port_a_io follows ack_n. Macro undefined: the same word reports group_a_mode = 01.
